stage_fetch: RTL and testbench
==============================

# stage_fetch

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. Holds the program counter, the instruction memory (loadable by the debug loader), and the IF/ID pipeline register feeding decode's `i_pc` and `i_instruction`. It honours the hazard unit's PC-write and IF/ID-write stalls, redirects on taken branches and jumps, and freezes on a HALT instruction.

## Interface

Clocking and reset: one clock, `clk`; reset `reset` is asynchronous and active-high.

Parameters:
- `ADDR_W`, default 8: instruction-memory index width, so depth is 2^ADDR_W words.
- `HALT_WORD`, default 32'hFFFF_FFFF: encoding of the halt instruction.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous active-high reset.
- `i_enable`  in  1  debug run/step enable; 0 freezes PC, the IF/ID register and the halt flag.
- `i_pc_write`  in  1  from hazard unit; 0 holds PC (load-use stall).
- `i_write_IF_ID`  in  1  from hazard unit; 0 holds the IF/ID register.
- `i_branch_taken`  in  1  taken-branch redirect from the branch unit.
- `i_branch_addr`  in  32  branch target, in word units.
- `i_jump`  in  1  jump redirect.
- `i_jump_addr`  in  32  jump target, in word units (decode's zero-extended 8-bit field).
- `i_mem_we`  in  1  loader write strobe.
- `i_mem_addr`  in  ADDR_W  loader word address.
- `i_mem_data`  in  32  loader write data.
- `o_pc`  out  32  IF/ID: PC+1 of the latched instruction, to decode `i_pc`.
- `o_instruction`  out  32  IF/ID: latched instruction, to decode `i_instruction`.
- `o_pc_current`  out  32  live PC register, for debug readout.
- `o_halt`  out  1  sticky halted flag.

## Operation

- PC counts words and increments by 1. Memory is read at `pc[ADDR_W-1:0]`, so upper PC bits alias. PC wraps modulo 2^32.
- Instruction memory: asynchronous read, synchronous write on `i_mem_we`. A write is visible to reads from the next cycle. Writes are accepted regardless of `i_enable`.
- Per-edge PC update, first matching rule wins:
  1. `i_enable`=0: hold.
  2. `o_halt`=1: hold.
  3. `i_branch_taken`: PC <= `i_branch_addr`.
  4. `i_jump`: PC <= `i_jump_addr`.
  5. `i_pc_write`=0: hold.
  6. Otherwise: PC <= PC+1.
- Per-edge IF/ID update, first matching rule wins:
  1. `i_enable`=0: hold.
  2. `i_branch_taken` or `i_jump`: flush, instruction <= 0 (NOP), pc <= 0.
  3. `o_halt`=1: hold.
  4. `i_write_IF_ID`=0: hold.
  5. Otherwise: instruction <= mem[PC], pc <= PC+1.
- Halt flag:
  - Set at the edge where the fetched word equals `HALT_WORD`, `i_enable`=1, no flush, and `i_write_IF_ID`=1. The HALT word is latched into IF/ID on that same edge so it propagates downstream.
  - Once set, it stays set until reset. Later branches and jumps still flush IF/ID but do not move PC.
- Two states: RUN and HALTED. RUN goes to HALTED on the condition above; HALTED goes to RUN only on reset.

## Timing

- Reset (asynchronous, effective immediately): PC=0, `o_pc`=0, `o_instruction`=0, `o_halt`=0, memory contents untouched.
- Fetch latency is 1 cycle: mem[PC] appears on `o_instruction` after the next rising edge.
- Redirect: the target's instruction reaches `o_instruction` 2 edges after redirect assertion, with a NOP in between. This is a 1-bubble penalty.
- Stall: with `i_pc_write`=0 and `i_write_IF_ID`=0 for N cycles, both outputs are constant for N cycles.
- Branch and stall in the same cycle: the branch wins, and both PC and IF/ID update.
- Branch and jump in the same cycle: the branch target is used.
- Reset deasserting mid-program: fetch restarts at PC=0 on the first enabled edge.

## Test plan

- Load words 0..3 = A,B,C,D, then run with `i_enable`=1. Required: `o_instruction` shows A,B,C,D on successive edges, and `o_pc` shows 1,2,3,4.
- Stall: hold `i_pc_write`=0 and `i_write_IF_ID`=0 for 2 cycles while B is in IF/ID. Required: `o_instruction`=B for 3 cycles total, then C.
- Branch: assert `i_branch_taken` with `i_branch_addr`=0x10 while PC=3. Required: next edge gives `o_instruction`=0 and `o_pc_current`=0x10; the following edge gives mem[0x10] with `o_pc`=0x11. Also assert a stall in the same cycle; the outcome must be unchanged.
- Halt: place word 2 = 32'hFFFF_FFFF. Required: `o_instruction`=FFFF_FFFF and `o_halt`=1 after the third edge; PC stays 2 for 10 more cycles; a later `i_jump` does not change PC.
- Reset mid-run: assert `reset` asynchronously between edges at PC=5. Required: outputs go to 0 immediately without waiting for an edge; after release, word 0 is fetched first.
- Wrap and debug freeze: set PC to 0x1FF via branch with ADDR_W=8. Required: mem[0xFF] is fetched, then PC=0x200 fetches mem[0x00]. With `i_enable`=0, all outputs stay constant while a loader write still lands in memory.

Source files
------------

// File: rtl/stage_fetch.sv
// Instruction-fetch stage: program counter, loader-writable instruction memory
// and the IF/ID register feeding decode. Freezes permanently on the HALT word.
module stage_fetch #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic              i_pc_write,
  input  logic              i_write_IF_ID,
  input  logic              i_branch_taken,
  input  logic [31:0]       i_branch_addr,
  input  logic              i_jump,
  input  logic [31:0]       i_jump_addr,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [31:0]       i_mem_data,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_instruction,
  output logic [31:0]       o_pc_current,
  output logic              o_halt
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t      state;
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] pc;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] fetch_word;
  logic        flush;
  logic        halt_hit;

  // Upper PC bits alias onto the memory index.
  assign fetch_word = mem[pc[ADDR_W-1:0]];
  assign flush      = i_branch_taken | i_jump;
  assign halt_hit   = (state == RUN) && i_enable && !flush && i_write_IF_ID &&
                      (fetch_word == HALT_WORD);

  always_ff @(posedge clk) begin
    if (i_mem_we) mem[i_mem_addr] <= i_mem_data;
  end

  // Memory is not reset; only the pipeline state is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      pc       <= 32'd0;
      if_pc    <= 32'd0;
      if_instr <= 32'd0;
    end else if (i_enable) begin
      // PC stays parked on the HALT word's own address.
      if (state == HALTED || halt_hit) begin
        pc <= pc;
      end else if (i_branch_taken) begin
        pc <= i_branch_addr;
      end else if (i_jump) begin
        pc <= i_jump_addr;
      end else if (i_pc_write) begin
        pc <= pc + 32'd1;
      end

      if (flush) begin
        if_instr <= 32'd0;
        if_pc    <= 32'd0;
      end else if (state == RUN && i_write_IF_ID) begin
        if_instr <= fetch_word;
        if_pc    <= pc + 32'd1;
      end

      if (halt_hit) state <= HALTED;
    end
  end

  assign o_pc          = if_pc;
  assign o_instruction = if_instr;
  assign o_pc_current  = pc;
  assign o_halt        = (state == HALTED);

endmodule

// File: tb/tb_stage_fetch.sv
// Bench for stage_fetch: vector table applied through an expected-value queue,
// plus hand-written reset, halt and freeze sequences.
module tb_stage_fetch;

  localparam int          ADDR_W = 8;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
  localparam int          W      = 97;

  typedef struct {
    logic        en;
    logic        pcw;
    logic        wif;
    logic        br;
    logic [31:0] baddr;
    logic        jmp;
    logic [31:0] jaddr;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_cur;
    logic        exp_halt;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_enable;
  logic              i_pc_write;
  logic              i_write_IF_ID;
  logic              i_branch_taken;
  logic [31:0]       i_branch_addr;
  logic              i_jump;
  logic [31:0]       i_jump_addr;
  logic              i_mem_we;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [31:0]       i_mem_data;
  logic [31:0]       o_pc;
  logic [31:0]       o_instruction;
  logic [31:0]       o_pc_current;
  logic              o_halt;

  logic [W-1:0] exp_q[$];
  logic [31:0]  model_mem [0:255];
  vec_t         tbl[$];
  int           checks = 0;
  int           errors = 0;

  stage_fetch #(.ADDR_W(ADDR_W), .HALT_WORD(HALT)) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_pc_write(i_pc_write),
    .i_write_IF_ID(i_write_IF_ID), .i_branch_taken(i_branch_taken),
    .i_branch_addr(i_branch_addr), .i_jump(i_jump), .i_jump_addr(i_jump_addr),
    .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
    .o_pc(o_pc), .o_instruction(o_instruction), .o_pc_current(o_pc_current),
    .o_halt(o_halt)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic pcw, input logic wif,
                              input logic br, input logic [31:0] baddr,
                              input logic jmp, input logic [31:0] jaddr,
                              input logic [31:0] ei, input logic [31:0] ep,
                              input logic [31:0] ec, input logic eh);
    vec_t v;
    v.en = en; v.pcw = pcw; v.wif = wif; v.br = br; v.baddr = baddr;
    v.jmp = jmp; v.jaddr = jaddr; v.exp_instr = ei; v.exp_pc = ep;
    v.exp_cur = ec; v.exp_halt = eh;
    return v;
  endfunction

  function automatic vec_t run(input logic [31:0] ei, input logic [31:0] ep,
                               input logic [31:0] ec, input logic eh);
    return mk(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, ei, ep, ec, eh);
  endfunction

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    i_mem_we   = 1'b1;
    i_mem_addr = a;
    i_mem_data = d;
    @(posedge clk); #1;
    i_mem_we   = 1'b0;
    model_mem[a] = d;
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    logic [W-1:0] e;
    i_enable       = v.en;
    i_pc_write     = v.pcw;
    i_write_IF_ID  = v.wif;
    i_branch_taken = v.br;
    i_branch_addr  = v.baddr;
    i_jump         = v.jmp;
    i_jump_addr    = v.jaddr;
    exp_q.push_back({v.exp_halt, v.exp_cur, v.exp_pc, v.exp_instr});
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard_empty actual=0 required=1", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " instr"}, o_instruction, e[31:0]);
      check({tag, " pc"},    o_pc,          e[63:32]);
      check({tag, " pc_cur"}, o_pc_current, e[95:64]);
      check({tag, " halt"},  {31'd0, o_halt}, {31'd0, e[96]});
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " instr"}, o_instruction, 32'd0);
    check({tag, " pc"},    o_pc,          32'd0);
    check({tag, " pc_cur"}, o_pc_current, 32'd0);
    check({tag, " halt"},  {31'd0, o_halt}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b1; i_enable = 1'b0; i_pc_write = 1'b1; i_write_IF_ID = 1'b1;
    i_branch_taken = 1'b0; i_branch_addr = 32'd0; i_jump = 1'b0; i_jump_addr = 32'd0;
    i_mem_we = 1'b0; i_mem_addr = '0; i_mem_data = 32'd0;

    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w == HALT) w = 32'h1234_5678;
      load(i[7:0], w);
    end
    check_zero("reset_state");
    reset = 1'b0;

    tbl.push_back(run(model_mem[0], 32'd1, 32'd1, 1'b0));
    tbl.push_back(run(model_mem[1], 32'd2, 32'd2, 1'b0));
    tbl.push_back(run(model_mem[2], 32'd3, 32'd3, 1'b0));
    tbl.push_back(run(model_mem[3], 32'd4, 32'd4, 1'b0));
    tbl.push_back(run(model_mem[4], 32'd5, 32'd5, 1'b0));
    tbl.push_back(run(model_mem[0], 32'd1, 32'd1, 1'b0));   // first edge after reset
    tbl.push_back(run(model_mem[1], 32'd2, 32'd2, 1'b0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, model_mem[1], 32'd2, 32'd2, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, model_mem[1], 32'd2, 32'd2, 0));
    tbl.push_back(run(model_mem[2], 32'd3, 32'd3, 1'b0));
    tbl.push_back(mk(1, 0, 0, 1, 32'h10, 0, 0, 32'd0, 32'd0, 32'h10, 0));
    tbl.push_back(run(model_mem[8'h10], 32'h11, 32'h11, 1'b0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 32'h20, 32'd0, 32'd0, 32'h20, 0));
    tbl.push_back(run(model_mem[8'h20], 32'h21, 32'h21, 1'b0));
    tbl.push_back(mk(1, 1, 1, 1, 32'h30, 1, 32'h40, 32'd0, 32'd0, 32'h30, 0));
    tbl.push_back(run(model_mem[8'h30], 32'h31, 32'h31, 1'b0));
    tbl.push_back(mk(1, 1, 1, 1, 32'h1FF, 0, 0, 32'd0, 32'd0, 32'h1FF, 0));
    tbl.push_back(run(model_mem[8'hFF], 32'h200, 32'h200, 1'b0));
    tbl.push_back(run(model_mem[8'h00], 32'h201, 32'h201, 1'b0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, model_mem[1], 32'h202, 32'h201, 0));
    tbl.push_back(run(model_mem[1], 32'h202, 32'h202, 1'b0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, model_mem[1], 32'h202, 32'h203, 0));
    tbl.push_back(run(model_mem[3], 32'h204, 32'h204, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 5) begin
        // asynchronous reset between edges with PC=5
        #3 reset = 1'b1;
        #1 check_zero("async_reset");
        #2 reset = 1'b0;
      end
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // halt sequence
    reset = 1'b1;
    load(8'd2, HALT);
    check_zero("reset_halt");
    reset = 1'b0;
    apply(run(model_mem[0], 32'd1, 32'd1, 1'b0), "halt_e1");
    apply(run(model_mem[1], 32'd2, 32'd2, 1'b0), "halt_e2");
    apply(run(HALT, 32'd3, 32'd2, 1'b1), "halt_e3");
    for (int i = 0; i < 10; i++) apply(run(HALT, 32'd3, 32'd2, 1'b1), "halt_hold");
    apply(mk(1, 1, 1, 0, 0, 1, 32'h50, 32'd0, 32'd0, 32'd2, 1), "halt_jump");
    apply(mk(1, 1, 1, 1, 32'h60, 0, 0, 32'd0, 32'd0, 32'd2, 1), "halt_branch");
    apply(run(32'd0, 32'd0, 32'd2, 1'b1), "halt_after");

    // debug freeze with a loader write landing meanwhile
    reset = 1'b1;
    #1 reset = 1'b0;
    apply(run(model_mem[0], 32'd1, 32'd1, 1'b0), "frz_e1");
    apply(run(model_mem[1], 32'd2, 32'd2, 1'b0), "frz_e2");
    w = $urandom_range(32'h0FFF_FFFF, 0);
    i_mem_we = 1'b1; i_mem_addr = 8'd2; i_mem_data = w;
    apply(mk(0, 1, 1, 1, 32'h40, 1, 32'h44, model_mem[1], 32'd2, 32'd2, 0), "frz_wr");
    i_mem_we = 1'b0;
    model_mem[2] = w;
    apply(mk(0, 1, 1, 0, 0, 0, 0, model_mem[1], 32'd2, 32'd2, 0), "frz_hold1");
    apply(mk(0, 0, 0, 1, 32'h70, 0, 0, model_mem[1], 32'd2, 32'd2, 0), "frz_hold2");
    apply(run(model_mem[2], 32'd3, 32'd3, 1'b0), "frz_resume");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
